// File: rtl/noc_packetizer_if.sv
// Request and flit-link bundle for the NoC packetizer.
// master is the packetizer side, slave is the core/DMA plus router side.
interface noc_packetizer_if #(
   parameter int unsigned FLIT_WIDTH = 32,
   parameter int unsigned MAX_FLITS  = 8
);
   localparam int unsigned LEN_W = $clog2(MAX_FLITS + 1);

   logic [MAX_FLITS*FLIT_WIDTH-1:0] req_data;
   logic [LEN_W-1:0]                req_len;
   logic                            req_valid;
   logic                            req_ready;
   logic [FLIT_WIDTH-1:0]           out_flit;
   logic                            out_last;
   logic                            out_valid;
   logic                            out_ready;
   logic                            busy;
   logic                            err_len;

   modport master (
      input  req_data, req_len, req_valid, out_ready,
      output req_ready, out_flit, out_last, out_valid, busy, err_len
   );

   modport slave (
      output req_data, req_len, req_valid, out_ready,
      input  req_ready, out_flit, out_last, out_valid, busy, err_len
   );
endinterface

// File: rtl/noc_packetizer.sv
// Serializes one parallel packet per request onto a flit/last/valid/ready link.
// Illegal lengths are dropped with a one-cycle err_len pulse.
module noc_packetizer #(
   parameter int unsigned FLIT_WIDTH = 32,
   parameter int unsigned MAX_FLITS  = 8
) (
   input logic              clk,
   input logic              rst,
   noc_packetizer_if.master bus
);
   localparam int unsigned LEN_W = $clog2(MAX_FLITS + 1);
   localparam int unsigned CNT_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state, state_n;
   logic [FLIT_WIDTH-1:0] flits_q [MAX_FLITS];
   logic [LEN_W-1:0]      len_q;
   logic [CNT_W-1:0]      cnt;
   logic                  err_q;

   logic last, fire, ready, accept, legal;

   always_comb begin
      last   = (LEN_W'(cnt) == (len_q - LEN_W'(1)));
      fire   = (state == SEND) && bus.out_ready;
      // Combinational out_ready -> req_ready path lets packets run back-to-back.
      ready  = (state == IDLE) || (fire && last);
      accept = bus.req_valid && ready;
      legal  = (bus.req_len != '0) && (bus.req_len <= LEN_W'(MAX_FLITS));
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (accept && legal) state_n = SEND;
         SEND: if (fire && last) state_n = (accept && legal) ? SEND : IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_n;
         err_q <= accept && !legal;
         if (accept && legal)
            cnt <= '0;
         else if (fire && !last)
            cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept && legal) begin
         len_q <= bus.req_len;
         for (int unsigned i = 0; i < MAX_FLITS; i++)
            flits_q[i] <= bus.req_data[i*FLIT_WIDTH +: FLIT_WIDTH];
      end
   end

   always_comb begin
      bus.req_ready = ready;
      bus.out_valid = (state == SEND);
      bus.busy      = (state == SEND);
      bus.out_flit  = flits_q[cnt];
      bus.out_last  = last;
      bus.err_len   = err_q;
   end
endmodule

// File: tb/tb_noc_packetizer.sv
// Directed and random stimulus for noc_packetizer, checked every cycle
// against a queue of expected flits.
module tb_noc_packetizer;
   localparam int unsigned FW    = 32;
   localparam int unsigned MF    = 8;
   localparam int unsigned LEN_W = $clog2(MF + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   noc_packetizer_if #(.FLIT_WIDTH(FW), .MAX_FLITS(MF)) bus ();

   noc_packetizer #(.FLIT_WIDTH(FW), .MAX_FLITS(MF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference: the flits still owed for the current packet, oldest first.
   logic [FW-1:0] q [$];
   bit            err_exp  = 0;
   bit            live     = 0;
   bit            last_acc = 0;
   int unsigned   dut_fires = 0;
   int unsigned   dut_errs  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      bit fire, acc, legal, do_rst;
      logic [MF*FW-1:0] d;
      int unsigned len;
      @(negedge clk);
      fire = 0; acc = 0; legal = 0;
      len  = int'(bus.req_len);
      d    = bus.req_data;
      do_rst = rst;
      if (live) begin
         check("out_valid", bus.out_valid, q.size() != 0);
         check("busy", bus.busy, q.size() != 0);
         check("req_ready", bus.req_ready,
               (q.size() == 0) || (bus.out_ready && q.size() == 1));
         check("err_len", bus.err_len, err_exp);
         if (q.size() != 0) begin
            check("out_flit", bus.out_flit, q[0]);
            check("out_last", bus.out_last, q.size() == 1);
         end
         fire  = (q.size() != 0) && bus.out_ready;
         acc   = bus.req_valid && ((q.size() == 0) || (fire && q.size() == 1));
         legal = (len >= 1) && (len <= MF);
         if (bus.out_valid === 1'b1 && bus.out_ready) dut_fires++;
         if (bus.err_len === 1'b1) dut_errs++;
      end
      @(posedge clk);
      last_acc = 0;
      if (do_rst) begin
         q.delete();
         err_exp = 0;
         live    = 1;
      end else if (live) begin
         last_acc = acc;
         if (fire) void'(q.pop_front());
         err_exp = acc && !legal;
         if (acc && legal)
            for (int i = 0; i < len; i++) q.push_back(d[i*FW +: FW]);
      end
      #1;
   endtask

   task automatic set_req(input int unsigned len, input logic [MF*FW-1:0] d, input logic v);
      bus.req_len   = LEN_W'(len);
      bus.req_data  = d;
      bus.req_valid = v;
   endtask

   function automatic logic [MF*FW-1:0] seq_data(input int unsigned base);
      logic [MF*FW-1:0] d;
      for (int i = 0; i < MF; i++) d[i*FW +: FW] = FW'(base + i);
      return d;
   endfunction

   function automatic logic [MF*FW-1:0] rand_data();
      logic [MF*FW-1:0] d;
      for (int i = 0; i < MF; i++) d[i*FW +: FW] = $urandom;
      return d;
   endfunction

   int unsigned f0, e0;

   initial begin
      rst = 1'b1;
      bus.out_ready = 1'b0;
      set_req(0, '0, 1'b0);
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_ready", bus.req_ready, 1'b1);

      // 1: basic 3-flit packet
      bus.out_ready = 1'b1;
      set_req(3, seq_data(32'hA), 1'b1);
      tick();
      set_req(0, rand_data(), 1'b0);
      repeat (4) tick();

      // 2: backpressure on a 4-flit packet
      set_req(4, seq_data(1), 1'b1);
      tick();
      set_req(0, rand_data(), 1'b0);
      f0 = dut_fires;
      begin
         bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
         foreach (pat[i]) begin
            bus.out_ready = pat[i];
            tick();
         end
      end
      check("bp_xfers", dut_fires - f0, 4);
      bus.out_ready = 1'b1;
      tick();

      // 3: illegal lengths 0 and MF+1
      e0 = dut_errs;
      set_req(0, rand_data(), 1'b1);
      tick();
      set_req(MF + 1, rand_data(), 1'b1);
      tick();
      set_req(0, rand_data(), 1'b0);
      repeat (2) tick();
      check("err_pulses", dut_errs - e0, 2);

      // 4: back-to-back, second request waits on a stalled last flit
      set_req(3, seq_data(7), 1'b1);
      tick();
      set_req(2, seq_data(5), 1'b1);
      tick(); tick();
      bus.out_ready = 1'b0;
      tick(); tick();
      check("b2b_held", last_acc, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      check("b2b_accept", last_acc, 1'b1);
      set_req(0, rand_data(), 1'b0);
      repeat (3) tick();

      // 5: single flit and max length
      set_req(1, seq_data(32'h11), 1'b1);
      tick();
      set_req(0, '0, 1'b0);
      repeat (2) tick();
      set_req(MF, seq_data(32'h20), 1'b1);
      tick();
      set_req(0, '0, 1'b0);
      repeat (MF + 1) tick();

      // 6: reset mid-packet, then a fresh 2-flit packet
      set_req(5, rand_data(), 1'b1);
      tick();
      set_req(0, '0, 1'b0);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_valid", bus.out_valid, 1'b0);
      check("rst_mid_ready", bus.req_ready, 1'b1);
      set_req(2, seq_data(32'h40), 1'b1);
      tick();
      set_req(0, '0, 1'b0);
      repeat (3) tick();

      // Random traffic with occasional illegal lengths and resets
      for (int n = 0; n < 3000; n++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         set_req($urandom_range(0, MF + 1), rand_data(), $urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      set_req(0, '0, 1'b0);
      bus.out_ready = 1'b1;
      repeat (MF + 2) tick();
      check("drain_empty", bus.out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
- Transmit-side counterpart of the router input FIFO. Accepts one whole packet per request as a parallel word plus a flit count, and serializes it onto the flit/last/valid/ready link that feeds a router input buffer.
- Sits in the network interface between the local core/DMA and the local router port.
- Guarantees in-order flit emission, correct last-flit marking, and stable outputs under backpressure.

Parameters:
- FLIT_WIDTH, 32: width of one flit in bits.
- MAX_FLITS, 8: maximum packet length in flits. Must be >= 1.
- LEN_W, $clog2(MAX_FLITS+1): localparam, width of the length field.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- req_data, input, MAX_FLITS*FLIT_WIDTH: packet payload. Flit i is req_data[i*FLIT_WIDTH +: FLIT_WIDTH]. Flit 0 is sent first.
- req_len, input, LEN_W: number of flits in the packet. Valid range is 1..MAX_FLITS.
- req_valid, input, 1: request valid.
- req_ready, output, 1: request accepted when req_valid && req_ready.
- out_flit, output, FLIT_WIDTH: current flit.
- out_last, output, 1: high on the final flit of a packet.
- out_valid, output, 1: flit valid.
- out_ready, input, 1: downstream ready. A flit transfers on out_valid && out_ready (out_fire).
- busy, output, 1: high while a packet is being serialized (state SEND).
- err_len, output, 1: one-cycle pulse when a request with an illegal length is consumed.

Behaviour:
- State machine:
  - IDLE -> SEND on a legal request accept.
  - SEND -> SEND when the last flit fires and a new legal request is accepted in the same cycle.
  - SEND -> IDLE when the last flit fires with no new accept, or when the new accept is illegal.
  - rst -> IDLE from any state.
- Reset values: state=IDLE, out_valid=0, busy=0, err_len=0, flit counter=0. out_flit and out_last are don't-care while out_valid=0.
- req_ready = (state==IDLE) || (state==SEND && out_fire && out_last).
  - This is a combinational path from out_ready to req_ready. It is intentional and allows packets to go back-to-back with no bubble.
- On accept with 1 <= req_len <= MAX_FLITS:
  - req_data and req_len are captured into internal registers; the counter is set to 0.
  - Next cycle: state=SEND, out_valid=1, out_flit = captured flit 0.
  - Input ports may change freely after the accept.
- On accept with req_len==0 or req_len>MAX_FLITS:
  - err_len=1 for exactly the next cycle.
  - Nothing is captured. The request counts as consumed (dropped).
  - If accepted while the last flit fires, the state goes to IDLE.
- In SEND:
  - out_valid=1.
  - out_flit = captured flit[cnt].
  - out_last = (cnt == len-1).
- On out_fire with !out_last: cnt increments and the next flit is presented the following cycle.
- With out_valid=1 and out_ready=0: out_flit, out_last and out_valid hold stable. No flit is skipped or duplicated.
- Throughput and latency:
  - With out_ready held high, an N-flit packet occupies exactly N cycles.
  - First-flit latency is 1 cycle after accept.
- out_valid never depends combinationally on out_ready.
- Reset mid-packet: the remaining flits are discarded, out_valid=0 in the cycle after rst, and the next packet starts at flit 0.
- Counter width: $clog2(MAX_FLITS), minimum 1. It never wraps, because the length check bounds it to len-1.

Test Plan:
1. Basic 3-flit packet. req_len=3, flits {0xA,0xB,0xC}, out_ready=1 -> cycles +1,+2,+3 show out_flit 0xA,0xB,0xC; out_last=1 only on 0xC; busy=1 over those 3 cycles, then 0.
2. Backpressure. 4-flit packet {1,2,3,4}, out_ready pattern 1,0,0,1,0,1,1 -> exactly 4 transfers in order 1,2,3,4; out_flit stable through every stall cycle; out_last=1 only with flit 4.
3. Illegal length. req_len=0, then req_len=9 with MAX_FLITS=8 -> err_len pulses once per request (2 pulses total); out_valid stays 0; req_ready stays 1.
4. Back-to-back. Second request (len=2, {0x5,0x6}) held valid while the first packet's last flit is stalled -> it is accepted in the cycle the last flit fires; 0x5 appears the very next cycle with no idle gap.
5. Single flit and max length.
   - len=1 -> one flit with out_last=1, then IDLE.
   - len=8 -> 8 flits, out_last only on flit 7.
6. Reset mid-packet. rst asserted after 2 of 5 flits have transferred -> out_valid=0 and req_ready=1 next cycle; a following len=2 packet emits its flit 0 first.
